// File: rtl/mem_access_stage_pkg.sv
// Shared constants for the MEM stage: memop/funct3 encodings, FSM states
// and the MEM latch packing that the WB stage unpacks.
package mem_access_stage_pkg;

    localparam logic [1:0] MEMOP_NONE  = 2'd0;
    localparam logic [1:0] MEMOP_LOAD  = 2'd1;
    localparam logic [1:0] MEMOP_STORE = 2'd2;
    localparam logic [1:0] MEMOP_RSVD  = 2'd3;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_WAIT_RSP = 1'b1;

    // MEM latch, MSB first: {valid, rd, wr_reg, data, inst_count}
    function automatic int memlat_w(int dbits, int regbits);
        return 2 + regbits + 2 * dbits;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/response port: one ready/valid request channel
// and a valid-only response channel.
interface mem_access_stage_if #(
    parameter int DBITS = 32
) ();
    logic             dmem_req_valid;
    logic             dmem_req_ready;
    logic             dmem_req_we;
    logic [DBITS-1:0] dmem_req_addr;
    logic [DBITS-1:0] dmem_req_wdata;
    logic [3:0]       dmem_req_wstrb;
    logic             dmem_rsp_valid;
    logic [DBITS-1:0] dmem_rsp_rdata;

    modport master (
        output dmem_req_valid, dmem_req_we, dmem_req_addr,
        output dmem_req_wdata, dmem_req_wstrb,
        input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
    );

    modport slave (
        input  dmem_req_valid, dmem_req_we, dmem_req_addr,
        input  dmem_req_wdata, dmem_req_wstrb,
        output dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
    );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store data replication/strobes and load
// extract with sign or zero extension.
module mem_lane_align
    import mem_access_stage_pkg::*;
#(
    parameter int DBITS = 32
) (
    input  logic [1:0]       addr_i,
    input  logic [2:0]       size_i,
    input  logic [DBITS-1:0] st_data_i,
    input  logic [DBITS-1:0] ld_word_i,
    output logic [DBITS-1:0] st_data_o,
    output logic [3:0]       st_strb_o,
    output logic [DBITS-1:0] ld_data_o
);
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic        sx;

    assign ld_b = ld_word_i[{addr_i, 3'b000} +: 8];
    assign ld_h = ld_word_i[{addr_i[1], 4'b0000} +: 16];
    assign sx   = !size_i[2];

    always_comb begin
        st_data_o = st_data_i;
        st_strb_o = 4'hF;
        ld_data_o = ld_word_i;
        unique case (size_i[1:0])
            F3_B[1:0]: begin
                st_data_o = {4{st_data_i[7:0]}};
                st_strb_o = 4'b0001 << addr_i;
                ld_data_o = {{24{ld_b[7] & sx}}, ld_b};
            end
            F3_H[1:0]: begin
                st_data_o = {2{st_data_i[15:0]}};
                st_strb_o = 4'b0011 << {addr_i[1], 1'b0};
                ld_data_o = {{16{ld_h[15] & sx}}, ld_h};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores, holds upstream on outstanding
// loads, fills the MEM latch. Option: MEM_MISALIGN_TRAP_EN.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DBITS     = 32,
    parameter int REGNOBITS = 5,
    parameter int CNTBITS   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 agex_valid,
    input  logic [1:0]           agex_memop,
    input  logic [2:0]           agex_size,
    input  logic [DBITS-1:0]     agex_aluout,
    input  logic [DBITS-1:0]     agex_wdata,
    input  logic [REGNOBITS-1:0] agex_rd,
    input  logic                 agex_wr_reg,
    input  logic [DBITS-1:0]     agex_inst_count,
    output logic                 mem_stall,
    mem_access_stage_if.master   dmem,
    output logic                 wb_valid,
    output logic [REGNOBITS-1:0] wb_rd,
    output logic                 wb_wr_reg,
    output logic [DBITS-1:0]     wb_data,
    output logic [DBITS-1:0]     wb_inst_count,
    output logic                 fwd_valid,
    output logic [REGNOBITS-1:0] fwd_rd,
    output logic [DBITS-1:0]     fwd_data,
    output logic [CNTBITS-1:0]   stall_cycles
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                 misalign_trap
`endif
);
    localparam int LATW = memlat_w(DBITS, REGNOBITS);

    logic [0:0]         state_q, state_d;
    logic [LATW-1:0]    lat_q, lat_d;
    logic [CNTBITS-1:0] stall_q;
    logic               is_ld, is_st, mis, req_valid;
    logic [DBITS-1:0]   st_wdata, ld_data;
    logic [3:0]         st_strb;
`ifdef MEM_MISALIGN_TRAP_EN
    logic               trap_q, trap_d;
`endif

    assign is_ld = agex_valid && (agex_memop == MEMOP_LOAD);
    assign is_st = agex_valid && (agex_memop == MEMOP_STORE);

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis = (is_ld || is_st) &&
                 (((agex_size[1:0] == F3_H[1:0]) && agex_aluout[0]) ||
                  ((agex_size[1:0] == F3_W[1:0]) && (agex_aluout[1:0] != 2'b00)));
`else
    assign mis = 1'b0;
`endif

    mem_lane_align #(.DBITS(DBITS)) u_align (
        .addr_i    (agex_aluout[1:0]),
        .size_i    (agex_size),
        .st_data_i (agex_wdata),
        .ld_word_i (dmem.dmem_rsp_rdata),
        .st_data_o (st_wdata),
        .st_strb_o (st_strb),
        .ld_data_o (ld_data)
    );

    always_comb begin
        state_d   = state_q;
        lat_d     = '0;
        mem_stall = 1'b0;
        req_valid = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        trap_d    = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if ((is_ld || is_st) && !mis) begin
                    req_valid = 1'b1;
                    if (is_st) begin
                        // posted write: retire as soon as it is accepted
                        mem_stall = !dmem.dmem_req_ready;
                        if (dmem.dmem_req_ready)
                            lat_d = {1'b1, agex_rd, 1'b0, agex_aluout, agex_inst_count};
                    end else begin
                        mem_stall = 1'b1;
                        if (dmem.dmem_req_ready)
                            state_d = ST_WAIT_RSP;
                    end
                end else if (agex_valid) begin
                    lat_d = {1'b1, agex_rd, agex_wr_reg & !mis,
                             agex_aluout, agex_inst_count};
`ifdef MEM_MISALIGN_TRAP_EN
                    trap_d = mis;
`endif
                end
            end
            ST_WAIT_RSP: begin
                mem_stall = !dmem.dmem_rsp_valid;
                if (dmem.dmem_rsp_valid) begin
                    lat_d   = {1'b1, agex_rd, agex_wr_reg, ld_data, agex_inst_count};
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            lat_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            if (mem_stall)
                stall_q <= stall_q + CNTBITS'(1);
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) trap_q <= 1'b0;
        else       trap_q <= trap_d;
    end
    assign misalign_trap = trap_q;
`endif

    assign dmem.dmem_req_valid = req_valid;
    assign dmem.dmem_req_we    = is_st;
    assign dmem.dmem_req_addr  = {agex_aluout[DBITS-1:2], 2'b00};
    assign dmem.dmem_req_wdata = st_wdata;
    assign dmem.dmem_req_wstrb = st_strb;

    assign {wb_valid, wb_rd, wb_wr_reg, wb_data, wb_inst_count} = lat_q;
    assign fwd_valid    = wb_valid && wb_wr_reg && (wb_rd != '0);
    assign fwd_rd       = wb_rd;
    assign fwd_data     = wb_data;
    assign stall_cycles = stall_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a per-cycle reference model.
// Build with +define+MEM_MISALIGN_TRAP_EN to exercise the trap option.
module tb_mem_access_stage;

    typedef struct packed {
        logic        v;
        logic [4:0]  rd;
        logic        wr;
        logic [31:0] data;
        logic [31:0] tag;
        logic        trap;
    } wb_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        agex_valid;
    logic [1:0]  agex_memop;
    logic [2:0]  agex_size;
    logic [31:0] agex_aluout, agex_wdata, agex_inst_count;
    logic [4:0]  agex_rd;
    logic        agex_wr_reg;
    logic        mem_stall;
    logic        wb_valid, wb_wr_reg, fwd_valid;
    logic [4:0]  wb_rd, fwd_rd;
    logic [31:0] wb_data, wb_inst_count, fwd_data, stall_cycles;
    logic        trap_out;

    mem_access_stage_if #(.DBITS(32)) dmem_if ();

    mem_access_stage #(.DBITS(32), .REGNOBITS(5), .CNTBITS(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .agex_valid      (agex_valid),
        .agex_memop      (agex_memop),
        .agex_size       (agex_size),
        .agex_aluout     (agex_aluout),
        .agex_wdata      (agex_wdata),
        .agex_rd         (agex_rd),
        .agex_wr_reg     (agex_wr_reg),
        .agex_inst_count (agex_inst_count),
        .mem_stall       (mem_stall),
        .dmem            (dmem_if),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd),
        .wb_wr_reg       (wb_wr_reg),
        .wb_data         (wb_data),
        .wb_inst_count   (wb_inst_count),
        .fwd_valid       (fwd_valid),
        .fwd_rd          (fwd_rd),
        .fwd_data        (fwd_data),
        .stall_cycles    (stall_cycles)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misalign_trap   (trap_out)
`endif
    );

`ifndef MEM_MISALIGN_TRAP_EN
    assign trap_out = 1'b0;
`endif

    always #5 clk = ~clk;

    int          nvec = 0;
    int          nerr = 0;
    int          tag_ctr = 100;
    bit          chk_en = 0;
    wb_t         exp_wb;
    logic        exp_stall, exp_req, exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_strb;
    int unsigned exp_stall_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        nvec++;
        if (act !== want) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask

    function automatic logic [31:0] m_load(logic [31:0] w, logic [31:0] a, logic [2:0] sz);
        logic [31:0] v;
        case (sz)
            3'd0, 3'd4: begin
                v = (w >> (8 * a[1:0])) & 32'hFF;
                if (sz == 3'd0 && v >= 32'd128) v = v + 32'hFFFF_FF00;
            end
            3'd1, 3'd5: begin
                v = (w >> (16 * a[1])) & 32'hFFFF;
                if (sz == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    task automatic m_store(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d,
                           output logic [3:0] strb, output logic [31:0] wd);
        case (sz)
            3'd0: begin strb = 4'(1 << a[1:0]); wd = (d & 32'hFF) * 32'h0101_0101; end
            3'd1: begin strb = 4'(3 << (2 * a[1])); wd = (d & 32'hFFFF) * 32'h0001_0001; end
            default: begin strb = 4'hF; wd = d; end
        endcase
    endtask

    function automatic bit m_mis(logic [1:0] op, logic [2:0] sz, logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
        if (op != 2'd1 && op != 2'd2) return 0;
        return ((sz == 3'd1 || sz == 3'd5) && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00);
`else
        return 0;
`endif
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wb_valid", 32'(wb_valid), 32'(exp_wb.v));
            if (exp_wb.v) begin
                chk("wb_rd", 32'(wb_rd), 32'(exp_wb.rd));
                chk("wb_wr_reg", 32'(wb_wr_reg), 32'(exp_wb.wr));
                chk("wb_data", wb_data, exp_wb.data);
                chk("wb_tag", wb_inst_count, exp_wb.tag);
            end
            chk("fwd_valid", 32'(fwd_valid), 32'(exp_wb.v && exp_wb.wr && exp_wb.rd != 0));
            if (exp_wb.v && exp_wb.wr && exp_wb.rd != 0) begin
                chk("fwd_rd", 32'(fwd_rd), 32'(exp_wb.rd));
                chk("fwd_data", fwd_data, exp_wb.data);
            end
            chk("trap", 32'(trap_out), 32'(exp_wb.v && exp_wb.trap));
            chk("mem_stall", 32'(mem_stall), 32'(exp_stall));
            chk("req_valid", 32'(dmem_if.dmem_req_valid), 32'(exp_req));
            if (exp_req) begin
                chk("req_we", 32'(dmem_if.dmem_req_we), 32'(exp_we));
                chk("req_addr", dmem_if.dmem_req_addr, exp_addr);
                if (exp_we) begin
                    chk("req_wstrb", 32'(dmem_if.dmem_req_wstrb), 32'(exp_strb));
                    chk("req_wdata", dmem_if.dmem_req_wdata, exp_wdata);
                end
            end
            chk("stall_cycles", stall_cycles, exp_stall_cnt);
        end
    end

    task automatic tick(input bit ret, input wb_t e);
        @(posedge clk);
        if (exp_stall) exp_stall_cnt++;
        exp_wb = ret ? e : '0;
        #1;
    endtask

    task automatic idle(input logic [1:0] op);
        agex_valid = 1'b0;
        agex_memop = op;
        exp_stall = 1'b0;
        exp_req = 1'b0;
        tick(0, '0);
    endtask

    task automatic run(input logic [1:0] op, input logic [2:0] sz, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd, input logic wr,
                       input logic [31:0] rdata, input int rdy_d, input int rsp_d);
        wb_t e;
        bit  mis;
        tag_ctr++;
        agex_valid = 1'b1;
        agex_memop = op;
        agex_size = sz;
        agex_aluout = addr;
        agex_wdata = wd;
        agex_rd = rd;
        agex_wr_reg = wr;
        agex_inst_count = 32'(tag_ctr);
        mis = m_mis(op, sz, addr);
        e = '{v: 1'b1, rd: rd, wr: wr, data: addr, tag: 32'(tag_ctr), trap: 1'b0};
        exp_addr = addr & 32'hFFFF_FFFC;
        if (op == 2'd1 && !mis) begin
            exp_req = 1'b1;
            exp_we = 1'b0;
            for (int k = 0; k <= rdy_d; k++) begin
                dmem_if.dmem_req_ready = (k == rdy_d);
                exp_stall = 1'b1;
                tick(0, e);
            end
            dmem_if.dmem_req_ready = 1'b0;
            exp_req = 1'b0;
            e.data = m_load(rdata, addr, sz);
            for (int k = 1; k <= rsp_d; k++) begin
                dmem_if.dmem_rsp_valid = (k == rsp_d);
                dmem_if.dmem_rsp_rdata = (k == rsp_d) ? rdata : 32'hDEAD_BEEF;
                exp_stall = (k != rsp_d);
                tick(k == rsp_d, e);
            end
            dmem_if.dmem_rsp_valid = 1'b0;
        end else if (op == 2'd2 && !mis) begin
            exp_req = 1'b1;
            exp_we = 1'b1;
            m_store(addr, sz, wd, exp_strb, exp_wdata);
            e.wr = 1'b0;
            for (int k = 0; k <= rdy_d; k++) begin
                dmem_if.dmem_req_ready = (k == rdy_d);
                exp_stall = (k != rdy_d);
                tick(k == rdy_d, e);
            end
            dmem_if.dmem_req_ready = 1'b0;
        end else begin
            exp_req = 1'b0;
            exp_stall = 1'b0;
            if (mis) begin
                e.wr = 1'b0;
                e.trap = 1'b1;
            end
            tick(1, e);
        end
        agex_valid = 1'b0;
        exp_stall = 1'b0;
        exp_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        agex_valid = 1'b0;
        agex_memop = 2'd0;
        agex_size = 3'd0;
        agex_aluout = '0;
        agex_wdata = '0;
        agex_rd = '0;
        agex_wr_reg = 1'b0;
        agex_inst_count = '0;
        dmem_if.dmem_req_ready = 1'b0;
        dmem_if.dmem_rsp_valid = 1'b0;
        dmem_if.dmem_rsp_rdata = '0;
        exp_wb = '0;
        exp_stall = 1'b0;
        exp_req = 1'b0;
        exp_we = 1'b0;
        exp_addr = '0;
        exp_wdata = '0;
        exp_strb = '0;
        exp_stall_cnt = 0;

        #12;
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
        chk("rst_stall_cycles", stall_cycles, 32'd0);
        chk("rst_req_valid", 32'(dmem_if.dmem_req_valid), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1;
        idle(2'd0);

        run(2'd0, 3'd0, 32'h1234, 32'h0, 5'd5, 1'b1, 32'h0, 0, 0);
        chk("add_data", wb_data, 32'h0000_1234);
        chk("add_fwd_rd", 32'(fwd_rd), 32'd5);
        chk("add_fwd_valid", 32'(fwd_valid), 32'd1);
        run(2'd2, 3'd0, 32'h1003, 32'hAB, 5'd7, 1'b1, 32'h0, 0, 0);
        chk("sb_wr_reg", 32'(wb_wr_reg), 32'd0);
        idle(2'd0);
        run(2'd1, 3'd0, 32'h2001, 32'h0, 5'd9, 1'b1, 32'h0000_F000, 0, 3);
        chk("lb_data", wb_data, 32'hFFFF_FFF0);
        chk("lb_stall_cycles", stall_cycles, 32'd3);
        run(2'd1, 3'd5, 32'h2002, 32'h0, 5'd10, 1'b1, 32'h8001_0000, 2, 1);
        chk("lhu_data", wb_data, 32'h0000_8001);
        chk("lhu_stall_cycles", stall_cycles, 32'd6);
        run(2'd1, 3'd1, 32'h2000, 32'h0, 5'd11, 1'b1, 32'h1234_8765, 0, 1);
        chk("lh_data", wb_data, 32'hFFFF_8765);
        run(2'd1, 3'd4, 32'h2003, 32'h0, 5'd12, 1'b1, 32'h9A00_0000, 0, 2);
        chk("lbu_data", wb_data, 32'h0000_009A);
        run(2'd1, 3'd2, 32'h2004, 32'h0, 5'd13, 1'b1, 32'hCAFE_F00D, 1, 2);
        run(2'd2, 3'd1, 32'h1002, 32'h1234_ABCD, 5'd14, 1'b1, 32'h0, 1, 0);
        run(2'd2, 3'd2, 32'h1008, 32'h1122_3344, 5'd0, 1'b0, 32'h0, 0, 0);
        run(2'd3, 3'd0, 32'h0055, 32'h0, 5'd0, 1'b1, 32'h0, 0, 0);
        chk("rsvd_fwd_valid_rd0", 32'(fwd_valid), 32'd0);
        idle(2'd1);
        idle(2'd2);
        run(2'd1, 3'd2, 32'h3002, 32'h0, 5'd15, 1'b1, 32'h0BAD_CAFE, 0, 1);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis_lw_trap", 32'(trap_out), 32'd1);
        chk("mis_lw_wr_reg", 32'(wb_wr_reg), 32'd0);
`else
        chk("mis_lw_data", wb_data, 32'h0BAD_CAFE);
`endif
        run(2'd2, 3'd1, 32'h1001, 32'h0000_BEEF, 5'd16, 1'b1, 32'h0, 0, 0);
        run(2'd0, 3'd0, 32'hA5A5_0001, 32'h0, 5'd17, 1'b1, 32'h0, 0, 0);
        run(2'd0, 3'd0, 32'h5A5A_0002, 32'h0, 5'd18, 1'b0, 32'h0, 0, 0);
        idle(2'd0);

        // reset while a load is waiting for its response
        chk_en = 0;
        agex_valid = 1'b1;
        agex_memop = 2'd1;
        agex_size = 3'd2;
        agex_aluout = 32'h4000;
        agex_rd = 5'd3;
        agex_wr_reg = 1'b1;
        dmem_if.dmem_req_ready = 1'b1;
        @(posedge clk);
        #1 dmem_if.dmem_req_ready = 1'b0;
        chk("wait_rsp_stall", 32'(mem_stall), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        agex_valid = 1'b0;
        #1;
        chk("midrst_wb_valid", 32'(wb_valid), 32'd0);
        chk("midrst_stall_cycles", stall_cycles, 32'd0);
        chk("midrst_req_valid", 32'(dmem_if.dmem_req_valid), 32'd0);
        chk("midrst_mem_stall", 32'(mem_stall), 32'd0);
        chk("midrst_fwd_valid", 32'(fwd_valid), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        dmem_if.dmem_rsp_valid = 1'b1;
        dmem_if.dmem_rsp_rdata = 32'h7777_7777;
        @(posedge clk);
        #1 dmem_if.dmem_rsp_valid = 1'b0;
        chk("stray_wb_valid", 32'(wb_valid), 32'd0);
        chk("stray_mem_stall", 32'(mem_stall), 32'd0);
        chk("stray_stall_cycles", stall_cycles, 32'd0);
        exp_wb = '0;
        exp_stall = 1'b0;
        exp_req = 1'b0;
        exp_stall_cnt = 0;
        chk_en = 1;
        run(2'd0, 3'd0, 32'h0000_00C3, 32'h0, 5'd4, 1'b1, 32'h0, 0, 0);
        chk("post_rst_data", wb_data, 32'h0000_00C3);
        run(2'd1, 3'd0, 32'h2002, 32'h0, 5'd6, 1'b1, 32'h0055_0000, 0, 1);
        chk("post_rst_lb", wb_data, 32'h0000_0055);
        idle(2'd0);
        idle(2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
